sram1rw_req_ctrl: RTL and testbench

- Initiator-side controller for the single-port 1RW SRAM macros (the 128x12 family).
- Turns a valid/ready request channel into active-low SRAM pin activity (CSB/WEB/OEB/A/I), captures read data (O) one cycle later, and returns it on a valid/ready response channel with backpressure.
- After reset it zero-fills the whole array, because the macro powers up with random contents, then opens the request channel.

---
 rtl/sram1rw_req_ctrl_if.sv | 25 ++
 rtl/sram1rw_req_ctrl.sv | 119 +++++++++++
 tb/tb_sram1rw_req_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram1rw_req_ctrl_if.sv
// Request/response channel bundle for the 1RW SRAM controller.
// master = initiator side, slave = controller side.
interface sram1rw_req_ctrl_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/sram1rw_req_ctrl.sv
// Initiator-side controller for a 1RW SRAM macro: zero-fill after
// reset, then valid/ready requests with in-order buffered read data.
module sram1rw_req_ctrl #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 12,
    parameter int DEPTH   = 128,
    parameter bit INIT_EN = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    sram1rw_req_ctrl_if.slave bus,
    output logic              init_done,
    output logic              sram_csb,
    output logic              sram_web,
    output logic              sram_oeb,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_i,
    input  logic [DATA_W-1:0] sram_o
);
    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_nxt;
    logic              req_ready;
    logic              fire;
    logic              credit;
    logic              rd_pending;
    logic [DATA_W-1:0] fifo_q [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [1:0]        used;
    logic              resp_valid;
    logic              push;
    logic              pop;

    assign resp_valid     = (count != 2'd0) && !reset;
    assign pop            = resp_valid && bus.resp_ready;
    assign push           = rd_pending;
    assign used           = count + {1'b0, rd_pending};
    assign credit         = (used < 2'd2) || pop;
    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rdata = fifo_q[rd_ptr];

    // State and init address counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= INIT_EN ? S_INIT : S_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state, handshake and SRAM pin drive
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        init_done = 1'b0;
        req_ready = 1'b0;
        fire      = 1'b0;
        sram_csb  = 1'b1;
        sram_web  = 1'b1;
        sram_oeb  = 1'b1;
        sram_a    = bus.req_addr;
        sram_i    = bus.req_wdata;
        if (!reset) begin
            unique case (state)
                S_INIT: begin
                    sram_csb = 1'b0;
                    sram_web = 1'b0;
                    sram_a   = cnt[ADDR_W-1:0];
                    sram_i   = '0;
                    cnt_nxt  = cnt + 1'b1;
                    if (cnt == LAST) state_nxt = S_RUN;
                end
                S_RUN: begin
                    init_done = 1'b1;
                    req_ready = bus.req_write || credit;
                    fire      = bus.req_valid && req_ready;
                    sram_csb  = !fire;
                    sram_web  = !(fire && bus.req_write);
                    sram_oeb  = !(fire && !bus.req_write);
                end
                default: ;
            endcase
        end
    end

    // Read pipeline tracking and response FIFO occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_pending <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
        end else begin
            rd_pending <= fire && !bus.req_write;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) rd_ptr <= ~rd_ptr;
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    // Response FIFO storage, captures SRAM output one cycle after a read
    always_ff @(posedge clock) begin
        if (push) fifo_q[wr_ptr] <= sram_o;
    end
endmodule

// File: tb/tb_sram1rw_req_ctrl.sv
// Randomized scoreboard bench for sram1rw_req_ctrl with a behavioural
// SRAM macro and a word-array reference model.
module tb_sram1rw_req_ctrl;
    localparam int AW    = 7;
    localparam int DW    = 12;
    localparam int DEPTH = 128;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sram1rw_req_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    sram1rw_req_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();

    logic          init_done, csb, web, oeb;
    logic [AW-1:0] a;
    logic [DW-1:0] di, dout;
    logic          init_done0, csb0, web0, oeb0;
    logic [AW-1:0] a0;
    logic [DW-1:0] di0;
    logic [DW-1:0] dout0;
    assign dout0 = '0;

    sram1rw_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .INIT_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .bus(bus), .init_done(init_done),
        .sram_csb(csb), .sram_web(web), .sram_oeb(oeb),
        .sram_a(a), .sram_i(di), .sram_o(dout)
    );

    sram1rw_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .INIT_EN(1'b0)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0), .init_done(init_done0),
        .sram_csb(csb0), .sram_web(web0), .sram_oeb(oeb0),
        .sram_a(a0), .sram_i(di0), .sram_o(dout0)
    );

    // Behavioural 1RW macro with registered read port
    logic [DW-1:0] mem [DEPTH];
    initial for (int k = 0; k < DEPTH; k++) mem[k] = DW'($urandom);
    always @(posedge clock) begin
        if (!csb && !web) mem[a] <= di;
        if (!csb && web && !oeb) dout <= mem[a];
    end

    // Reference model and scoreboard
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            iss_q [$];
    int            checks = 0;
    int            fails = 0;
    int            cyc = 0;
    int            run = 0;
    int            max_run = 0;
    bit            run_phase = 1'b0;
    bit            hv;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // Monitor: predicts handshakes from the model and pops responses
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            check("rst_resp_valid", bus.resp_valid, 0);
            check("rst_csb", csb, 1);
            check("rst_web", web, 1);
            check("rst_oeb", oeb, 1);
            check("rst_req_ready", bus.req_ready, 0);
            check("rst_init_done", init_done, 0);
        end else begin
            hv = 1'b0;
            if (exp_q.size() > 0) hv = (cyc - iss_q[0]) >= 2;
            check("resp_valid", bus.resp_valid, hv);
            if (run_phase)
                check("req_ready", bus.req_ready,
                      bus.req_write || exp_q.size() < 2 || (hv && bus.resp_ready));
            if (hv && bus.resp_ready) begin
                check("resp_rdata", bus.resp_rdata, exp_q.pop_front());
                void'(iss_q.pop_front());
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (bus.req_valid && bus.req_ready) begin
                if (bus.req_write) begin
                    ref_mem[bus.req_addr] = bus.req_wdata;
                end else begin
                    exp_q.push_back(ref_mem[bus.req_addr]);
                    iss_q.push_back(cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic init_window();
        for (int k = 0; k <= DEPTH; k++) begin
            @(negedge clock);
            if (k < DEPTH) begin
                check("init_csb", csb, 0);
                check("init_web", web, 0);
                check("init_oeb", oeb, 1);
                check("init_a", a, k);
                check("init_i", di, 0);
                check("init_done_low", init_done, 0);
                check("init_ready_low", bus.req_ready, 0);
            end else begin
                check("init_done_high", init_done, 1);
                check("run_ready", bus.req_ready, 1);
                check("run_idle_csb", csb, 1);
            end
            check("noinit_csb", csb0, 1);
            if (k == 0) begin
                check("noinit_done", init_done0, 1);
                check("noinit_ready", bus0.req_ready, 1);
            end
        end
        run_phase = 1'b1;
        tick();
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        run_phase = 1'b0;
        idle();
        exp_q.delete();
        iss_q.delete();
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
        for (int k = 0; k < n; k++) tick();
        reset = 1'b0;
        init_window();
    endtask

    task automatic issue(bit wr, int ad, int d, bit now);
        int w = 0;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = AW'(ad);
        bus.req_wdata = DW'(d);
        @(negedge clock);
        if (now) check("ready_now", bus.req_ready, 1);
        while (!bus.req_ready && w < 50) begin
            @(negedge clock);
            w++;
        end
        if (!bus.req_ready) begin
            checks++;
            fails++;
            $display("FAIL issue_timeout: req_ready stuck at 0 for addr %0h", ad);
        end
        tick();
    endtask

    task automatic drain();
        int w = 0;
        bus.resp_ready = 1'b1;
        while (exp_q.size() != 0 && w < 100) begin
            tick();
            w++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        idle();
        bus.resp_ready  = 1'b1;
        bus0.req_valid  = 1'b0;
        bus0.req_write  = 1'b0;
        bus0.req_addr   = '0;
        bus0.req_wdata  = '0;
        bus0.resp_ready = 1'b1;

        do_reset(3);

        issue(0, 'h55, 0, 1);
        idle();
        drain();

        issue(1, 'h10, 'hABC, 1);
        issue(0, 'h10, 0, 1);
        idle();
        @(negedge clock);
        check("lat_t1_valid", bus.resp_valid, 0);
        tick();
        @(negedge clock);
        check("lat_t2_valid", bus.resp_valid, 1);
        check("lat_t2_data", bus.resp_rdata, 'hABC);
        tick();
        drain();

        for (int k = 1; k <= 4; k++) issue(1, k, k, 1);
        idle();
        tick();
        max_run = 0;
        for (int k = 1; k <= 4; k++) issue(0, k, 0, 1);
        idle();
        repeat (6) tick();
        check("stream_run", max_run, 4);

        bus.resp_ready = 1'b0;
        issue(0, 1, 0, 1);
        issue(0, 2, 0, 1);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 3;
        repeat (3) begin
            @(negedge clock);
            check("bp_read_blocked", bus.req_ready, 0);
            tick();
        end
        bus.req_write = 1'b1;
        bus.req_addr  = 7;
        bus.req_wdata = 'h777;
        @(negedge clock);
        check("bp_write_ok", bus.req_ready, 1);
        tick();
        bus.req_write  = 1'b0;
        bus.req_addr   = 3;
        bus.resp_ready = 1'b1;
        @(negedge clock);
        check("bp_ready_release", bus.req_ready, 1);
        tick();
        idle();
        drain();

        issue(1, 'h20, 'h5A5, 1);
        issue(1, 'h21, 'h3C3, 1);
        bus.resp_ready = 1'b0;
        issue(0, 'h20, 0, 1);
        issue(0, 'h21, 0, 1);
        idle();
        repeat (3) tick();
        @(negedge clock);
        check("pre_rst_valid", bus.resp_valid, 1);
        tick();
        bus.resp_ready = 1'b1;
        do_reset(2);
        issue(0, 'h20, 0, 1);
        issue(0, 'h21, 0, 0);
        idle();
        drain();

        for (int n = 0; n < 1500; n++) begin
            bus.req_valid  = ($urandom_range(0, 9) < 7);
            bus.req_write  = ($urandom_range(0, 9) < 4);
            bus.req_addr   = AW'($urandom_range(0, 15));
            bus.req_wdata  = DW'($urandom);
            bus.resp_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        idle();
        drain();
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
